ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage.
- Consumes the EX-side operands and decoded op that the ID/EX pipeline register delivers.
- Holds architectural HI/LO.
- Drives a stall back toward IF/ID and ID/EX so dependent instructions wait while an operation is in flight.

Parameters:
XLEN, 32, operand width; HI/LO width.
CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  synchronous reset, active low
start  in  1  begin operation with op/op_a/op_b this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
op_a  in  XLEN  multiplicand / dividend (op_E_1 path)
op_b  in  XLEN  multiplier / divisor (op_E_2 path)
flush  in  1  abort any operation; suppress start this cycle
rd_hilo  in  1  EX instruction reads HI or LO (mfhi/mflo)
hi_we  in  1  mthi: write wdata to HI
lo_we  in  1  mtlo: write wdata to LO
wdata  in  XLEN  data for mthi/mtlo
hi  out  XLEN  HI register
lo  out  XLEN  LO register
busy  out  1  operation in flight (state != IDLE)
stall  out  1  combinational: busy & (start | rd_hilo | hi_we | lo_we)
done  out  1  one-cycle pulse after HI/LO written by an operation
div_zero  out  1  one-cycle pulse with done when divisor was 0

Behaviour:
- Reset (clr_n=0 at edge): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0. Reset mid-operation discards it.
- Reset has priority over flush, which has priority over all else.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 & flush=0 at edge E0: latch abs values (signed ops) or raw values (unsigned ops); record sign_a, sign_b, op, b_zero; counter=0; go to CALC.
  - hi_we/lo_we update HI/LO in IDLE only.
  - start with hi_we/lo_we in the same cycle: write applies and operation starts.
- CALC: one radix-2 step per edge, E1..E32.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per step.
  - Counter increments each step; at the edge where counter=XLEN-1, go to FIN.
- FIN, edge E33:
  - Multiply: 64-bit product negated if signed and sign_a^sign_b; HI=product[63:32], LO=product[31:0].
  - Divide: quotient negated if signed and sign_a^sign_b; remainder negated if signed and sign_a.
  - Divide then writes LO=quotient, HI=remainder.
  - Go to IDLE. done=1 for the cycle after E33.
- Divide by zero: LO=32'hFFFFFFFF, HI=op_a as latched raw (no sign fixup); div_zero=1 with done. Latency unchanged.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0, no flag.
- busy=1 from after E0 through E33.
- Total latency: start at E0 to HI/LO valid after E33 (34 edges).
- start, rd_hilo, hi_we, lo_we while busy:
  - stall=1; the requesting instruction is held upstream.
  - start is ignored and hi_we/lo_we are not applied; the op is reissued after busy drops.
- flush while busy: next edge returns to IDLE; HI/LO unchanged; no done; counter=0.
- flush in IDLE with start: no operation begins.
- hi/lo outputs are the registers directly; intermediate results are never visible.

Test Plan:
1. Hold clr_n=0 two cycles, release -> hi=0, lo=0, busy=0, done=0; mtlo wdata=0x1234 -> lo=0x00001234 next cycle.
2. MULT op_a=0xFFFFFFFD (-3), op_b=7 -> busy after E0, done the cycle after E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU 0x55/0 -> lo=0xFFFFFFFF, hi=0x00000055, div_zero=1 together with done.
5. MULT 5×5, then flush at iteration 10 -> busy=0 next cycle; hi/lo keep prior values; done never pulses.
6. While busy: start, rd_hilo, and hi_we=1 (wdata=0xAA) each -> stall=1 each cycle; hi unaffected; operation result unchanged. After done: stall=0, and a retried mthi writes hi=0xAA.

Source files
------------

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative 32-bit multiply/divide unit for the EX stage.
//                Radix-2 shift-add multiply and restoring divide, one step
//                per clock, holding architectural HI/LO and stalling the
//                front end while an operation is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  input  logic            rd_hilo,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic                r_done;
  logic                r_dz;
  logic [XLEN-1:0]     r_opnd;     // multiplicand (mult) or divisor (div), magnitude
  logic [2*XLEN-1:0]   r_acc;      // {partial product | remainder, multiplier | quotient}
  logic [XLEN-1:0]     r_raw_a;    // unmodified dividend, returned in HI on divide-by-zero
  logic                r_sign_a;
  logic                r_sign_b;
  logic                r_is_div;
  logic                r_signed;
  logic                r_bzero;

  // Operand capture: signed ops take magnitudes, unsigned ops pass through.
  logic            w_signed_in;
  logic            w_sa_in;
  logic            w_sb_in;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_signed_in = ~op[0];
  assign w_sa_in     = w_signed_in & op_a[XLEN-1];
  assign w_sb_in     = w_signed_in & op_b[XLEN-1];
  assign w_abs_a     = w_sa_in ? (~op_a + 1'b1) : op_a;
  assign w_abs_b     = w_sb_in ? (~op_b + 1'b1) : op_b;

  // Multiply step: conditionally add multiplicand to upper half, shift right.
  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_mstep;

  assign w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mstep = {w_madd, r_acc[XLEN-1:1]};

  // Divide step: shift left, trial-subtract divisor, keep result if no borrow.
  // When the subtraction succeeds the true difference is below the divisor,
  // so the low XLEN bits of the modular subtract are exact.
  logic [XLEN:0]     w_rem_sh;
  logic              w_qbit;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_dstep;

  assign w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_qbit   = (w_rem_sh >= {1'b0, r_opnd});
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_opnd;
  assign w_dstep  = {(w_qbit ? w_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit};

  // Final sign fixups applied on the FIN edge.
  logic              w_neg_res;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_neg_res = r_signed & (r_sign_a ^ r_sign_b);
  assign w_prod    = w_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quo     = w_neg_res ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem     = (r_signed & r_sign_a) ? (~r_acc[2*XLEN-1:XLEN] + 1'b1)
                                           : r_acc[2*XLEN-1:XLEN];

  // Sequencer: capture operands, iterate, then commit HI/LO and pulse done.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_raw_a  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_bzero  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_signed <= w_signed_in;
            r_sign_a <= w_sa_in;
            r_sign_b <= w_sb_in;
            r_bzero  <= (op_b == '0);
            r_raw_a  <= op_a;
            r_opnd   <= op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {{XLEN{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_dstep : w_mstep;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_done  <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
          end else if (r_bzero) begin
            r_hi <= r_raw_a;
            r_lo <= '1;
            r_dz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Hold requesters upstream whenever the unit is occupied.
  assign busy     = (r_state != S_IDLE);
  assign stall    = busy & (start | rd_hilo | hi_we | lo_we);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign done     = r_done;
  assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Self-checking bench for ex_muldiv; directed and random
//                operations compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        rd_hilo;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .rd_hilo(rd_hilo), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain architectural arithmetic.
  task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    rdz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (mop)
      2'b00: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1;
        end else if (mop == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rhi = 32'd0; rlo = 32'h8000_0000;
        end else if (mop == 2'b10) begin
          rlo = 32'(sa / sb); rhi = 32'(sa % sb);
        end else begin
          rlo = a / b; rhi = a % b;
        end
      end
    endcase
  endtask

  task automatic start_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = mop; op_a = a; op_b = b;
    #1 check("stall_idle", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_E0", {31'b0, busy}, 32'd1);
  endtask

  task automatic finish_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                           input int already);
    logic [31:0] rhi;
    logic [31:0] rlo;
    logic        rdz;
    int          n;
    model(mop, a, b, rhi, rlo, rdz);
    n = already;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd33);
    check("hi", hi, rhi);
    check("lo", lo, rlo);
    check("div_zero", {31'b0, div_zero}, {31'b0, rdz});
    check("busy_at_done", {31'b0, busy}, 32'd0);
    exp_hi = rhi;
    exp_lo = rlo;
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    start_op(mop, a, b);
    finish_op(mop, a, b, 0);
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    clr_n = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    flush = 1'b0; rd_hilo = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    // Reset and mtlo
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h0000_1234);

    // Directed multiply / divide cases
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    run_op(2'b11, 32'd100, 32'd7);
    check("divu_lo", lo, 32'd14);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", lo, 32'h8000_0000);
    run_op(2'b11, 32'h55, 32'd0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0);
    run_op(2'b10, 32'h7FFF_FFFF, 32'h8000_0000);

    // Flush mid-operation: no result, no done
    start_op(2'b00, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hi", hi, exp_hi);
    check("flush_lo", lo, exp_lo);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("flush_no_done", 32'(seen), 32'd0);

    // Flush together with start in IDLE: nothing begins
    start = 1'b1; op = 2'b01; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);

    // Requests while busy are stalled and ignored
    start_op(2'b01, 32'h1234_5678, 32'h0000_9ABC);
    @(negedge clk);
    start = 1'b1; op = 2'b11; op_a = 32'd9; op_b = 32'd3;
    #1 check("stall_start", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; rd_hilo = 1'b1;
    #1 check("stall_rdhilo", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rd_hilo = 1'b0; hi_we = 1'b1; wdata = 32'hAA;
    #1 check("stall_mthi", {31'b0, stall}, 32'd1);
    @(negedge clk);
    hi_we = 1'b0;
    finish_op(2'b01, 32'h1234_5678, 32'h0000_9ABC, 4);
    hi_we = 1'b1; wdata = 32'hAA;
    #1 check("stall_idle_mthi", {31'b0, stall}, 32'd0);
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_retry", hi, 32'h0000_00AA);

    // Reset mid-operation discards it
    start_op(2'b00, 32'd11, 32'd13);
    repeat (5) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_lo", lo, 32'd0);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {{16{rb[15]}}, rb[15:0]};
      run_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
